time_of_day_counter: RTL and testbench



---
 rtl/clock_pkg.sv | 49 ++++
 rtl/seg7_encode.sv | 19 +
 rtl/time_of_day_counter.sv | 172 +++++++++++++++++
 tb/tb_time_of_day_counter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared limits, digit glyphs and BCD split helpers for the time-of-day clock.
// Glyphs are active-high {g,f,e,d,c,b,a}; polarity is applied at the encoder output.
package clock_pkg;

  localparam logic [5:0] SEC_MAX     = 6'd59;
  localparam logic [5:0] MIN_MAX     = 6'd59;
  localparam logic [4:0] HOUR_MAX    = 5'd23;
  localparam logic [4:0] HOUR12_NOON = 5'd12;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Inputs are always within 0..59, so both results fit in one BCD digit.
  function automatic logic [3:0] tens_digit(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units_digit(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-to-segment encoder with optional blanking and output polarity.
module seg7_encode
  import clock_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  logic [6:0] glyph;

  always_comb begin
    glyph = i_blank ? SEG_BLANK : seg_glyph(i_digit);
    o_seg = ACTIVE_LOW ? ~glyph : glyph;
  end

endmodule

// File: rtl/time_of_day_counter.sv
// hh:mm:ss real-time clock: prescaled 1 Hz tick, validated time set, and a
// registered six-digit seven-segment display in 24 h or 12 h format.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_mode12,
  input  logic       i_set_valid,
  input  logic [4:0] i_set_h,
  input  logic [5:0] i_set_m,
  input  logic [5:0] i_set_s,
  output logic       o_set_ack,
  output logic       o_set_err,
  output logic       o_tick,
  output logic       o_pm,
  output logic [6:0] o_sec0,
  output logic [6:0] o_sec1,
  output logic [6:0] o_min0,
  output logic [6:0] o_min1,
  output logic [6:0] o_h0,
  output logic [6:0] o_h1
);

  localparam int              PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [6:0]      SEG_RESET = SEG_ACTIVE_LOW ? ~SEG_0 : SEG_0;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             pm_q, pm_d;

  logic [6:0] sec0_q, sec1_q, min0_q, min1_q, h0_q, h1_q;
  logic [6:0] sec0_d, sec1_d, min0_d, min1_d, h0_d, h1_d;

  logic       set_in_range;
  logic [4:0] hour_disp;
  logic [3:0] h1_digit;
  logic       h1_blank;

  assign set_in_range = (i_set_h <= HOUR_MAX) && (i_set_m <= MIN_MAX) && (i_set_s <= SEC_MAX);

  // i_set_valid is a level request sampled on every edge (no ready): each sampled
  // request yields exactly one o_set_ack or o_set_err pulse on the following cycle.
  always_comb begin
    pre_d  = pre_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    tick_d = 1'b0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    if (i_set_valid) begin
      if (set_in_range) begin
        sec_d  = i_set_s;
        min_d  = i_set_m;
        hour_d = i_set_h;
        pre_d  = '0;
        ack_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (i_en) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d  = '0;
            hour_d = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // 12 h view maps hour 0 to 12 and folds 13..23 down; the tens digit blanks when zero.
  always_comb begin
    hour_disp = hour_q;
    if (i_mode12) begin
      if (hour_q == 5'd0) begin
        hour_disp = HOUR12_NOON;
      end else if (hour_q > HOUR12_NOON) begin
        hour_disp = hour_q - HOUR12_NOON;
      end
    end
    h1_digit = tens_digit({1'b0, hour_disp});
    h1_blank = i_mode12 && (h1_digit == 4'd0);
    pm_d     = (hour_q >= HOUR12_NOON);
  end

  seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_sec0 (
    .i_digit(units_digit(sec_q)), .i_blank(1'b0), .o_seg(sec0_d)
  );
  seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_sec1 (
    .i_digit(tens_digit(sec_q)), .i_blank(1'b0), .o_seg(sec1_d)
  );
  seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_min0 (
    .i_digit(units_digit(min_q)), .i_blank(1'b0), .o_seg(min0_d)
  );
  seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_min1 (
    .i_digit(tens_digit(min_q)), .i_blank(1'b0), .o_seg(min1_d)
  );
  seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_h0 (
    .i_digit(units_digit({1'b0, hour_disp})), .i_blank(1'b0), .o_seg(h0_d)
  );
  seg7_encode #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc_h1 (
    .i_digit(h1_digit), .i_blank(h1_blank), .o_seg(h1_d)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      pre_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      pm_q   <= 1'b0;
      sec0_q <= SEG_RESET;
      sec1_q <= SEG_RESET;
      min0_q <= SEG_RESET;
      min1_q <= SEG_RESET;
      h0_q   <= SEG_RESET;
      h1_q   <= SEG_RESET;
    end else begin
      pre_q  <= pre_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      pm_q   <= pm_d;
      sec0_q <= sec0_d;
      sec1_q <= sec1_d;
      min0_q <= min0_d;
      min1_q <= min1_d;
      h0_q   <= h0_d;
      h1_q   <= h1_d;
    end
  end

  assign o_tick    = tick_q;
  assign o_set_ack = ack_q;
  assign o_set_err = err_q;
  assign o_pm      = pm_q;
  assign o_sec0    = sec0_q;
  assign o_sec1    = sec1_q;
  assign o_min0    = min0_q;
  assign o_min1    = min1_q;
  assign o_h0      = h0_q;
  assign o_h1      = h1_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: a CLK_HZ=4 active-low instance and a CLK_HZ=1
// active-high instance share one stimulus and are checked against a seconds-of-day model.
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode12 = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_h = '0;
  logic [5:0] set_m = '0;
  logic [5:0] set_s = '0;

  logic       ack_o  [2];
  logic       err_o  [2];
  logic       tick_o [2];
  logic       pm_o   [2];
  logic [6:0] seg_o  [2][6];

  int  cmp_cnt = 0;
  int  err_cnt = 0;
  bit  cmp_on  = 1'b0;

  // Model state, per instance: seconds of day, prescaler phase, registered outputs.
  int  m_tod  [2];
  int  m_pre  [2];
  bit  m_tick [2];
  bit  m_ack  [2];
  bit  m_err  [2];
  bit  m_pm   [2];
  int  m_dig  [2][6];

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  time_of_day_counter #(.CLK_HZ(4), .SEG_ACTIVE_LOW(1'b1)) u_dut4 (
    .clk(clk), .i_rst(rst), .i_en(en), .i_mode12(mode12),
    .i_set_valid(set_valid), .i_set_h(set_h), .i_set_m(set_m), .i_set_s(set_s),
    .o_set_ack(ack_o[0]), .o_set_err(err_o[0]), .o_tick(tick_o[0]), .o_pm(pm_o[0]),
    .o_sec0(seg_o[0][0]), .o_sec1(seg_o[0][1]), .o_min0(seg_o[0][2]),
    .o_min1(seg_o[0][3]), .o_h0(seg_o[0][4]), .o_h1(seg_o[0][5])
  );

  time_of_day_counter #(.CLK_HZ(1), .SEG_ACTIVE_LOW(1'b0)) u_dut1 (
    .clk(clk), .i_rst(rst), .i_en(en), .i_mode12(mode12),
    .i_set_valid(set_valid), .i_set_h(set_h), .i_set_m(set_m), .i_set_s(set_s),
    .o_set_ack(ack_o[1]), .o_set_err(err_o[1]), .o_tick(tick_o[1]), .o_pm(pm_o[1]),
    .o_sec0(seg_o[1][0]), .o_sec1(seg_o[1][1]), .o_min0(seg_o[1][2]),
    .o_min1(seg_o[1][3]), .o_h0(seg_o[1][4]), .o_h1(seg_o[1][5])
  );

  // ---------------------------------------------------------------- model helpers
  function automatic int hz_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Digit code 10 means a blanked position.
  function automatic logic [6:0] glyph(input int d, input bit active_low);
    logic [6:0] g;
    case (d)
      0: g = 7'b1000000;
      1: g = 7'b1111001;
      2: g = 7'b0100100;
      3: g = 7'b0110000;
      4: g = 7'b0011001;
      5: g = 7'b0010010;
      6: g = 7'b0000010;
      7: g = 7'b1111000;
      8: g = 7'b0000000;
      9: g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return active_low ? g : ~g;
  endfunction

  // Position j: 0 = sec units ... 5 = hour tens.
  function automatic int disp_digit(input int tod, input logic mode, input int j);
    int h, mi, s, dh;
    h  = tod / 3600;
    mi = (tod / 60) % 60;
    s  = tod % 60;
    dh = mode ? ((h + 11) % 12) + 1 : h;
    case (j)
      0: return s % 10;
      1: return s / 10;
      2: return mi % 10;
      3: return mi / 10;
      4: return dh % 10;
      default: return (mode && dh < 10) ? 10 : dh / 10;
    endcase
  endfunction

  function automatic logic [45:0] act_vec(input int k);
    return {tick_o[k], ack_o[k], err_o[k], pm_o[k],
            seg_o[k][5], seg_o[k][4], seg_o[k][3], seg_o[k][2], seg_o[k][1], seg_o[k][0]};
  endfunction

  function automatic logic [45:0] exp_vec(input int k);
    bit al;
    al = (k == 0);
    return {m_tick[k], m_ack[k], m_err[k], m_pm[k],
            glyph(m_dig[k][5], al), glyph(m_dig[k][4], al), glyph(m_dig[k][3], al),
            glyph(m_dig[k][2], al), glyph(m_dig[k][1], al), glyph(m_dig[k][0], al)};
  endfunction

  // ---------------------------------------------------------------- behavioural model
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_tod[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_ack[k] = 0; m_err[k] = 0; m_pm[k] = 0;
          for (int j = 0; j < 6; j++) m_dig[k][j] = 0;
        end else begin
          for (int j = 0; j < 6; j++) m_dig[k][j] = disp_digit(m_tod[k], mode12, j);
          m_pm[k]   = (m_tod[k] >= 12 * 3600);
          m_tick[k] = 0; m_ack[k] = 0; m_err[k] = 0;
          if (set_valid) begin
            if (set_h < 24 && set_m < 60 && set_s < 60) begin
              m_tod[k] = int'(set_h) * 3600 + int'(set_m) * 60 + int'(set_s);
              m_pre[k] = 0;
              m_ack[k] = 1;
            end else begin
              m_err[k] = 1;
            end
          end else if (en) begin
            if (m_pre[k] == hz_of(k) - 1) begin
              m_pre[k]  = 0;
              m_tod[k]  = (m_tod[k] + 1) % 86400;
              m_tick[k] = 1;
            end else begin
              m_pre[k] = m_pre[k] + 1;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- every-cycle compare
  initial begin
    wait (cmp_on);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        cmp_cnt++;
        if (act_vec(k) !== exp_vec(k)) begin
          err_cnt++;
          $display("FAIL model_cmp dut%0d t=%0t: got %h, want %h (tick,ack,err,pm,h1..s0)",
                   k, $time, act_vec(k), exp_vec(k));
        end
      end
    end
  end

  // ---------------------------------------------------------------- checks and drivers
  task automatic check_bit(input string name, input logic act, input logic exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name, input int k, input int d5, input int d4,
                            input int d3, input int d2, input int d1, input int d0,
                            input logic pm);
    logic [41:0] a, e;
    bit al;
    al = (k == 0);
    a = {seg_o[k][5], seg_o[k][4], seg_o[k][3], seg_o[k][2], seg_o[k][1], seg_o[k][0]};
    e = {glyph(d5, al), glyph(d4, al), glyph(d3, al), glyph(d2, al), glyph(d1, al), glyph(d0, al)};
    cmp_cnt++;
    if (a !== e || pm_o[k] !== pm) begin
      err_cnt++;
      $display("FAIL %s: got segs=%h pm=%b, want segs=%h pm=%b", name, a, pm_o[k], e, pm);
    end
  endtask

  task automatic do_set(input int h, input int m, input int s);
    @(negedge clk);
    set_valid = 1'b1;
    set_h = 5'(h);
    set_m = 6'(m);
    set_s = 6'(s);
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  // Counts negedges until the CLK_HZ=4 instance ticks; 0 means the bound expired.
  task automatic wait_tick(input string name, input int max_cyc, input int exp_cyc);
    int n;
    n = 0;
    for (int i = 1; i <= max_cyc && n == 0; i++) begin
      @(negedge clk);
      if (tick_o[0]) n = i;
    end
    check_int(name, n, exp_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n4, n1;
    #2 rst = 1'b1;
    cmp_on = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Reset asserted between edges while showing 13:05:00.
    do_set(13, 5, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_disp("rst_disp_dut4", 0, 0, 0, 0, 0, 0, 0, 1'b0);
    check_disp("rst_disp_dut1", 1, 0, 0, 0, 0, 0, 0, 1'b0);
    check_bit("rst_tick", tick_o[0], 1'b0);
    check_bit("rst_ack", ack_o[0], 1'b0);
    check_bit("rst_err", err_o[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick("first_tick_latency", 10, 4);
    @(negedge clk);
    check_disp("disp_000001", 0, 0, 0, 0, 0, 0, 1, 1'b0);

    // Midnight rollover.
    do_set(23, 59, 59);
    check_bit("ack_235959", ack_o[0], 1'b1);
    wait_tick("rollover_tick", 10, 4);
    @(negedge clk);
    check_disp("disp_000000", 0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Rejected and accepted sets.
    do_set(24, 0, 0);
    check_bit("err_h24", err_o[0], 1'b1);
    check_bit("noack_h24", ack_o[0], 1'b0);
    do_set(5, 60, 0);
    check_bit("err_m60", err_o[0], 1'b1);
    do_set(12, 34, 56);
    check_bit("ack_123456", ack_o[0], 1'b1);
    check_bit("noerr_123456", err_o[0], 1'b0);
    @(negedge clk);
    check_disp("disp_123456_dut4", 0, 1, 2, 3, 4, 5, 6, 1'b1);
    check_disp("disp_123456_dut1", 1, 1, 2, 3, 4, 5, 6, 1'b1);
    @(negedge clk);
    do_set(1, 2, 3);
    check_bit("set_beats_tick", tick_o[0], 1'b0);
    check_bit("ack_010203", ack_o[0], 1'b1);
    wait_tick("tick_after_set", 10, 4);
    @(negedge clk);
    check_disp("disp_010204", 0, 0, 1, 0, 2, 0, 4, 1'b0);

    // 12 h display.
    mode12 = 1'b1;
    do_set(0, 0, 0);
    @(negedge clk);
    check_disp("m12_h0", 0, 1, 2, 0, 0, 0, 0, 1'b0);
    do_set(12, 0, 0);
    @(negedge clk);
    check_disp("m12_h12", 0, 1, 2, 0, 0, 0, 0, 1'b1);
    do_set(13, 0, 0);
    @(negedge clk);
    check_disp("m12_h13", 0, 10, 1, 0, 0, 0, 0, 1'b1);
    mode12 = 1'b0;
    @(negedge clk);
    check_disp("m24_h13", 0, 1, 3, 0, 0, 0, 0, 1'b1);

    // Enable low at prescaler phase 2.
    do_set(5, 6, 7);
    repeat (2) @(negedge clk);
    en = 1'b0;
    n4 = 0;
    repeat (10) begin
      @(negedge clk);
      if (tick_o[0]) n4++;
    end
    check_int("no_tick_while_disabled", n4, 0);
    en = 1'b1;
    wait_tick("tick_after_reenable", 10, 2);
    @(negedge clk);
    check_disp("disp_050608", 0, 0, 5, 0, 6, 0, 8, 1'b0);

    // Free run across hour and midnight boundaries.
    do_set(22, 59, 50);
    n4 = 0;
    n1 = 0;
    repeat (14400) begin
      @(negedge clk);
      if (tick_o[0]) n4++;
      if (tick_o[1]) n1++;
    end
    en = 1'b0;
    @(negedge clk);
    check_int("freerun_ticks_dut4", n4, 3600);
    check_int("freerun_ticks_dut1", n1, 14400);
    check_disp("freerun_end_dut4", 0, 2, 3, 5, 9, 5, 0, 1'b1);
    check_disp("freerun_end_dut1", 1, 0, 2, 5, 9, 5, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
